ram2_arbiter_ctrl: RTL

Synchronous controller that owns the dataset RAM (`ram2`) pins and shares them between a write requester (host/loader) and a read requester (regression/multiplier datapath). It arbitrates between the two requesters and sequences each access so the RAM's address/we-triggered behaviour sees stable data. It also issues whole-memory clears and rejects out-of-range addresses. It sits between the loader/compute blocks and the single `ram2` instance.

---
 rtl/ram2_arbiter_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ram2_arbiter_ctrl.sv
// Arbitrated, sequenced access controller for the single dataset RAM (ram2).
// Shares the RAM pins between a write and a read requester and issues whole-memory clears.
module ram2_arbiter_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 100,
  parameter int CLR_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr_req,
  output logic                  clr_ack,
  output logic                  clr_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic                  wr_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  addr_err,
  output logic                  busy,
  output logic                  ram_oe,
  output logic                  ram_we,
  output logic                  ram_rst,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR_SETUP   = 3'd1;
  localparam logic [2:0] S_WR_HOLD    = 3'd2;
  localparam logic [2:0] S_RD_SETUP   = 3'd3;
  localparam logic [2:0] S_RD_CAPTURE = 3'd4;
  localparam logic [2:0] S_CLEAR      = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_CLR = 2'd2;

  localparam int                  CNT_W    = $clog2(CLR_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CLR_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] PARK   = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] LIMIT  = ADDR_WIDTH'(DEPTH);

  logic [2:0]            r_state;
  logic [1:0]            r_op;
  logic                  r_last_wr;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_ram_oe;
  logic                  r_ram_we;
  logic                  r_ram_rst;
  logic                  r_drv;
  logic [ADDR_WIDTH-1:0] r_ram_addr;

  logic                  w_idle;
  logic                  w_grant_clr;
  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_wr_oor;
  logic                  w_rd_oor;
  logic [2:0]            w_nxt;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic                  w_nxt_access;

  // Arbitration: clear first, then round-robin with the requester not served last winning ties.
  assign w_idle      = (r_state == S_IDLE);
  assign w_wr_oor    = (wr_addr >= LIMIT);
  assign w_rd_oor    = (rd_addr >= LIMIT);
  assign w_grant_clr = w_idle && clr_req;
  assign w_grant_wr  = w_idle && !clr_req && wr_req && (!rd_req || !r_last_wr);
  assign w_grant_rd  = w_idle && !clr_req && rd_req && !w_grant_wr;

  assign clr_ack  = w_grant_clr;
  assign wr_ack   = w_grant_wr;
  assign rd_ack   = w_grant_rd;
  assign addr_err = (w_grant_wr && w_wr_oor) || (w_grant_rd && w_rd_oor);
  assign busy     = !w_idle;
  assign wr_done  = (r_state == S_DONE) && (r_op == OP_WR);
  assign rd_valid = (r_state == S_DONE) && (r_op == OP_RD);
  assign clr_done = (r_state == S_DONE) && (r_op == OP_CLR);

  assign rd_data  = r_rd_data;
  assign ram_oe   = r_ram_oe;
  assign ram_we   = r_ram_we;
  assign ram_rst  = r_ram_rst;
  assign ram_addr = r_ram_addr;
  assign ram_data = r_drv ? r_wdata : {DATA_WIDTH{1'bz}};

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_clr)                  w_nxt = S_CLEAR;
        else if (w_grant_wr && !w_wr_oor) w_nxt = S_WR_SETUP;
        else if (w_grant_rd && !w_rd_oor) w_nxt = S_RD_SETUP;
      end
      S_WR_SETUP:   w_nxt = S_WR_HOLD;
      S_WR_HOLD:    w_nxt = S_DONE;
      S_RD_SETUP:   w_nxt = S_RD_CAPTURE;
      S_RD_CAPTURE: w_nxt = S_DONE;
      S_CLEAR:      w_nxt = (r_cnt == CLR_LAST) ? S_DONE : S_CLEAR;
      default:      w_nxt = S_IDLE;
    endcase
  end

  // The address being latched this edge must reach the RAM pins in the same cycle as the state.
  assign w_acc_addr   = w_idle ? (w_grant_wr ? wr_addr : rd_addr) : r_addr;
  assign w_nxt_access = (w_nxt == S_WR_SETUP) || (w_nxt == S_WR_HOLD) ||
                        (w_nxt == S_RD_SETUP) || (w_nxt == S_RD_CAPTURE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_op       <= OP_WR;
      r_last_wr  <= 1'b0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_ram_oe   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_rst  <= 1'b0;
      r_drv      <= 1'b0;
      r_ram_addr <= PARK;
    end else begin
      r_state <= w_nxt;
      if (w_grant_clr) begin
        r_op <= OP_CLR;
      end else if (w_grant_wr) begin
        r_op      <= OP_WR;
        r_last_wr <= 1'b1;
      end else if (w_grant_rd) begin
        r_op      <= OP_RD;
        r_last_wr <= 1'b0;
      end
      r_cnt      <= (r_state == S_CLEAR) ? r_cnt + 1'b1 : '0;
      r_ram_oe   <= (w_nxt == S_RD_SETUP) || (w_nxt == S_RD_CAPTURE);
      r_ram_we   <= (w_nxt == S_WR_HOLD);
      r_ram_rst  <= (w_nxt == S_CLEAR);
      r_drv      <= (w_nxt == S_WR_SETUP) || (w_nxt == S_WR_HOLD);
      r_ram_addr <= w_nxt_access ? w_acc_addr : PARK;
      if (r_state == S_RD_CAPTURE) r_rd_data <= ram_data;
    end
  end

  // Request payload latches carry no control meaning and are not reset.
  always_ff @(posedge CLK) begin
    if (w_grant_wr) begin
      r_addr  <= wr_addr;
      r_wdata <= wr_data;
    end else if (w_grant_rd) begin
      r_addr <= rd_addr;
    end
  end

endmodule
